e3_hlsm_sched: RTL and testbench
================================

// Module: e3_hlsm_sched
// PURPOSE
//  Multi-cycle, scheduled successor of the e3 combinational datapath: d=a+b, z=(d>e)?d:e, x=f-d.
//  - Parametrised widths; optional saturating arithmetic.
//  - Start/Done handshake with one operation per state.
//  - Registered outputs that hold their values between runs.
//  - Sits behind the netlist-generated control layer as one HLSM leaf.
// PARAMETERS
//  DATAW  8   width of signed narrow operands a, b, e and result z
//  WIDEW  16  width of signed wide operand f and result x; must be >= DATAW
//  SAT    0   0 = two's-complement wrap on add/sub; 1 = saturate to signed min/max
// PORTS
//  Clk    in   1      rising-edge clock
//  rst    in   1      asynchronous, active-high reset
//  Start  in   1      request; sampled only in state WAIT
//  a, b   in   DATAW  signed addends
//  e      in   DATAW  signed compare/mux operand
//  f      in   WIDEW  signed minuend
//  Done   out  1      one-cycle completion strobe
//  z      out  DATAW  signed registered result
//  x      out  WIDEW  signed registered result
// BEHAVIOUR
//  - Reset (async, any state): state=WAIT; Done=0, z=0, x=0; internal regs (a_r,b_r,e_r,f_r,d,gt)=0.
//  - FSM has 5 states (WAIT, S1, S2, S3, FINAL); transitions occur on rising Clk edges.
//  - WAIT: if Start=1, capture a, b, e, f into a_r, b_r, e_r, f_r and go to S1; otherwise stay.
//  - S1: d <= a_r + b_r at DATAW width (SAT=1 clamps to [-2^(DATAW-1), 2^(DATAW-1)-1]). Go to S2.
//  - S2: gt <= (d > e_r), signed compare; d==e_r gives gt=0. Go to S3.
//  - S3: z <= gt ? d : e_r.
//        x <= f_r - sext(d), computed at WIDEW width; d is SIGN-extended, and SAT clamps to WIDEW range.
//        Go to FINAL.
//  - FINAL: Done=1 (Moore output, decoded from state). Go to WAIT unconditionally.
//  - Latency: if Start is sampled at edge k, Done is high between edges k+3 and k+4, and z/x are
//    valid from edge k+3.
//  - Throughput: at most one run per 5 cycles; with Start held high, Done pulses every 5th cycle.
//  - Start in S1..FINAL is ignored; inputs may change freely after the capture edge.
//  - z and x hold their last values until the next S3 update; Done never stays high for two
//    consecutive cycles.
//  - Reset mid-run aborts the run: outputs clear at once, with no Done pulse.
//    Start sampled at the first edge after rst falls begins a new run.
// TESTING
//  1. DATAW=8, WIDEW=16, SAT=0: a=10, b=20, e=5, f=1000, pulse Start -> Done 4 edges later,
//     z=30, x=970.
//  2. SAT=0: a=100, b=100, e=3, f=0 -> d=-56, z=3, x=56.
//     SAT=1 with the same inputs -> d=127, z=127, x=-127.
//  3. Sign extension: a=-5, b=-3, e=-10, f=0 -> z=-8, x=8 (zero extension would wrongly give -248).
//  4. SAT=1: f=-32768, a=1, b=0 -> x=-32768. SAT=0 with the same inputs -> x=32767.
//  5. Hold Start=1 for 20 cycles -> exactly 4 Done pulses, 5 cycles apart.
//     Changing a/b mid-run does not affect the current run's result.
//  6. Assert rst while in S2 (async, between edges) -> Done, z, x go to 0 without waiting for a
//     clock edge. Release rst, pulse Start with test 1's inputs -> z=30, x=970 after the normal
//     latency.

Source files
------------

// File: rtl/e3_hlsm_sched.sv
// e3_hlsm_sched: scheduled d=a+b, z=max-like mux, x=f-d datapath.
// Five-state HLSM, one operation per state, registered results.
module e3_hlsm_sched #(
    parameter int DATAW = 8,
    parameter int WIDEW = 16,
    parameter bit SAT   = 1'b0
) (
    input  logic                    Clk,
    input  logic                    rst,
    input  logic                    Start,
    input  logic signed [DATAW-1:0] a,
    input  logic signed [DATAW-1:0] b,
    input  logic signed [DATAW-1:0] e,
    input  logic signed [WIDEW-1:0] f,
    output logic                    Done,
    output logic signed [DATAW-1:0] z,
    output logic signed [WIDEW-1:0] x
);

    typedef enum logic [2:0] {
        WAIT,
        S1,
        S2,
        S3,
        FINAL
    } state_t;

    localparam logic signed [DATAW-1:0] DMAX = {1'b0, {(DATAW-1){1'b1}}};
    localparam logic signed [DATAW-1:0] DMIN = {1'b1, {(DATAW-1){1'b0}}};
    localparam logic signed [WIDEW-1:0] WMAX = {1'b0, {(WIDEW-1){1'b1}}};
    localparam logic signed [WIDEW-1:0] WMIN = {1'b1, {(WIDEW-1){1'b0}}};

    state_t                  r_state;
    logic signed [DATAW-1:0] r_a;
    logic signed [DATAW-1:0] r_b;
    logic signed [DATAW-1:0] r_e;
    logic signed [WIDEW-1:0] r_f;
    logic signed [DATAW-1:0] r_d;
    logic                    r_gt;
    logic                    r_done;
    logic signed [DATAW-1:0] r_z;
    logic signed [WIDEW-1:0] r_x;

    logic signed [DATAW:0]   w_sum;
    logic signed [DATAW-1:0] w_d;
    logic signed [WIDEW-1:0] w_dext;
    logic signed [WIDEW:0]   w_diff;
    logic signed [WIDEW-1:0] w_x;

    // One guard bit exposes overflow; clamp or wrap depending on SAT
    always_comb begin
        w_sum  = (DATAW+1)'(r_a) + (DATAW+1)'(r_b);
        w_d    = w_sum[DATAW-1:0];
        w_dext = WIDEW'(r_d);
        w_diff = (WIDEW+1)'(r_f) - (WIDEW+1)'(w_dext);
        w_x    = w_diff[WIDEW-1:0];
        if (SAT && (w_sum[DATAW] != w_sum[DATAW-1])) begin
            w_d = w_sum[DATAW] ? DMIN : DMAX;
        end
        if (SAT && (w_diff[WIDEW] != w_diff[WIDEW-1])) begin
            w_x = w_diff[WIDEW] ? WMIN : WMAX;
        end
    end

    // Control and datapath registers; Done is registered on entry to FINAL
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT;
            r_a     <= '0;
            r_b     <= '0;
            r_e     <= '0;
            r_f     <= '0;
            r_d     <= '0;
            r_gt    <= 1'b0;
            r_done  <= 1'b0;
            r_z     <= '0;
            r_x     <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                WAIT: begin
                    if (Start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_e     <= e;
                        r_f     <= f;
                        r_state <= S1;
                    end
                end
                S1: begin
                    r_d     <= w_d;
                    r_state <= S2;
                end
                S2: begin
                    r_gt    <= (r_d > r_e);
                    r_state <= S3;
                end
                S3: begin
                    r_z     <= r_gt ? r_d : r_e;
                    r_x     <= w_x;
                    r_done  <= 1'b1;
                    r_state <= FINAL;
                end
                FINAL: begin
                    r_state <= WAIT;
                end
                default: begin
                    r_state <= WAIT;
                end
            endcase
        end
    end

    assign Done = r_done;
    assign z    = r_z;
    assign x    = r_x;

endmodule

// File: tb/tb_e3_hlsm_sched.sv
// tb_e3_hlsm_sched: scoreboard bench driving a wrap and a saturating
// instance in parallel with directed vectors.
module tb_e3_hlsm_sched;

    typedef struct {
        int z;
        int x;
    } exp_t;

    logic              Clk = 1'b0;
    logic              rst = 1'b1;
    logic              Start = 1'b0;
    logic signed [7:0] a = '0;
    logic signed [7:0] b = '0;
    logic signed [7:0] e = '0;
    logic signed [15:0] f = '0;
    logic              Done0, Done1;
    logic signed [7:0] z0, z1;
    logic signed [15:0] x0, x1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   last0 = -1;
    int   last1 = -1;
    int   dcnt0 = 0;
    int   dcnt1 = 0;
    bit   chk_gap = 1'b0;
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;

    always #5 Clk = ~Clk;

    e3_hlsm_sched #(.DATAW(8), .WIDEW(16), .SAT(1'b0)) u_wrap (
        .Clk(Clk), .rst(rst), .Start(Start),
        .a(a), .b(b), .e(e), .f(f),
        .Done(Done0), .z(z0), .x(x0)
    );

    e3_hlsm_sched #(.DATAW(8), .WIDEW(16), .SAT(1'b1)) u_sat (
        .Clk(Clk), .rst(rst), .Start(Start),
        .a(a), .b(b), .e(e), .f(f),
        .Done(Done1), .z(z1), .x(x1)
    );

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: pop and compare whenever a DUT signals Done
    always @(negedge Clk) begin
        exp_t ex;
        cyc++;
        if (Done0) begin
            dcnt0++;
            if (prev0) check("wrap_done_twice", 1, 0);
            if (chk_gap && last0 >= 0) check("wrap_gap", cyc - last0, 5);
            last0 = cyc;
            if (q0.size() == 0) check("wrap_unexpected_done", 1, 0);
            else begin
                ex = q0.pop_front();
                check("wrap_z", int'(z0), ex.z);
                check("wrap_x", int'(x0), ex.x);
            end
        end
        if (Done1) begin
            dcnt1++;
            if (prev1) check("sat_done_twice", 1, 0);
            if (chk_gap && last1 >= 0) check("sat_gap", cyc - last1, 5);
            last1 = cyc;
            if (q1.size() == 0) check("sat_unexpected_done", 1, 0);
            else begin
                ex = q1.pop_front();
                check("sat_z", int'(z1), ex.z);
                check("sat_x", int'(x1), ex.x);
            end
        end
        prev0 = Done0;
        prev1 = Done1;
    end

    task automatic push(int ez0, int ex0, int ez1, int ex1);
        q0.push_back('{z: ez0, x: ex0});
        q1.push_back('{z: ez1, x: ex1});
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 30 && (q0.size() + q1.size()) != 0; i++)
            @(negedge Clk);
        check(name, q0.size() + q1.size(), 0);
        repeat (2) @(negedge Clk);
    endtask

    task automatic run(int va, int vb, int ve, int vf,
                       int ez0, int ex0, int ez1, int ex1, string name);
        @(negedge Clk);
        a = 8'(va);
        b = 8'(vb);
        e = 8'(ve);
        f = 16'(vf);
        Start = 1'b1;
        push(ez0, ex0, ez1, ex1);
        @(negedge Clk);
        Start = 1'b0;
        a = 8'sd77;
        b = -8'sd77;
        drain(name);
    endtask

    initial begin
        int c0, c1;
        repeat (2) @(negedge Clk);
        check("rst_done0", int'(Done0), 0);
        check("rst_z0", int'(z0), 0);
        check("rst_x0", int'(x0), 0);
        check("rst_done1", int'(Done1), 0);
        check("rst_z1", int'(z1), 0);
        check("rst_x1", int'(x1), 0);
        rst = 1'b0;

        run(10, 20, 5, 1000, 30, 970, 30, 970, "t1_drain");
        run(100, 100, 3, 0, 3, 56, 127, -127, "t2_drain");
        run(-5, -3, -10, 0, -8, 8, -8, 8, "t3_drain");
        run(1, 0, 0, -32768, 1, 32767, 1, -32768, "t4_drain");
        run(-100, -100, 0, 0, 56, -56, 0, 128, "t4b_drain");

        // Start held high; a/b disturbed outside capture cycles
        c0 = dcnt0;
        c1 = dcnt1;
        last0 = -1;
        last1 = -1;
        chk_gap = 1'b1;
        e = 8'sd5;
        f = 16'sd1000;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            Start = 1'b1;
            if (i % 5 == 0) begin
                a = 8'sd10;
                b = 8'sd20;
                push(30, 970, 30, 970);
            end else begin
                a = 8'sd99;
                b = -8'sd7;
            end
        end
        @(negedge Clk);
        Start = 1'b0;
        drain("t5_drain");
        chk_gap = 1'b0;
        check("t5_pulses_wrap", dcnt0 - c0, 4);
        check("t5_pulses_sat", dcnt1 - c1, 4);

        // Async reset while in S2: no Done, outputs clear immediately
        @(negedge Clk);
        a = 8'sd10;
        b = 8'sd20;
        e = 8'sd5;
        f = 16'sd1000;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(posedge Clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_done0", int'(Done0), 0);
        check("t6_z0", int'(z0), 0);
        check("t6_x0", int'(x0), 0);
        check("t6_z1", int'(z1), 0);
        check("t6_x1", int'(x1), 0);
        @(negedge Clk);
        rst = 1'b0;
        Start = 1'b1;
        push(30, 970, 30, 970);
        @(negedge Clk);
        Start = 1'b0;
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
